// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter
//   Two-requester APB master. Two command sources share one APB bus. Each
//   command is a read or write, offered on a valid/ready handshake.
//   Requesters are arbitrated round-robin. The block runs the APB
//   SETUP/ACCESS sequence, waits for PREADY with an optional timeout, and
//   returns one response pulse to the requester that won.
//
// Ports
//   PCLK, PRESET            clock (rising edge), synchronous active-high reset
//   req_*_0 / req_*_1       command inputs and combinational req_ready outputs
//   rsp_*_0 / rsp_*_1       one-cycle rsp_valid pulse plus held rdata/err
//   PSEL..PWDATA            registered APB master outputs
//   PRDATA, PREADY, PSLVERR APB slave return path
//   state_dbg               current FSM state (IDLE=0, SETUP=1, ACCESS=2)
//
// Handshake: a command transfers on a cycle where req_valid_x and req_ready_x
// are both high. req_ready_x depends only on the FSM state, both valids and
// the round-robin pointer. It never depends on registered requester data.
// A requester may drop valid before ready; that command is simply not taken.
module apb_req_arbiter #(
  parameter int AWIDTH  = 4,
  parameter int DWIDTH  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              req_valid_0,
  output logic              req_ready_0,
  input  logic              req_write_0,
  input  logic [AWIDTH-1:0] req_addr_0,
  input  logic [DWIDTH-1:0] req_wdata_0,
  output logic              rsp_valid_0,
  output logic [DWIDTH-1:0] rsp_rdata_0,
  output logic              rsp_err_0,
  input  logic              req_valid_1,
  output logic              req_ready_1,
  input  logic              req_write_1,
  input  logic [AWIDTH-1:0] req_addr_1,
  input  logic [DWIDTH-1:0] req_wdata_1,
  output logic              rsp_valid_1,
  output logic [DWIDTH-1:0] rsp_rdata_1,
  output logic              rsp_err_1,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [AWIDTH-1:0] PADDR,
  output logic [DWIDTH-1:0] PWDATA,
  input  logic [DWIDTH-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
  localparam bit         TO_EN     = (TIMEOUT != 0);

  state_t     state;
  state_t     state_nxt;
  logic       last_grant;
  logic       owner;
  logic       winner;
  logic       any_valid;
  logic       accept;
  logic       done;
  logic       abort;
  logic [7:0] wait_cnt;

  // Only one valid: it wins. Both valid: whoever was not granted last wins.
  assign any_valid = req_valid_0 | req_valid_1;

  always_comb begin
    winner = req_valid_1;
    if (req_valid_0 && req_valid_1) begin
      winner = ~last_grant;
    end
  end

  assign accept      = (state == IDLE) && any_valid;
  assign req_ready_0 = accept && !winner;
  assign req_ready_1 = accept && winner;

  // PREADY takes priority over a timeout that would expire in the same cycle.
  assign done  = (state == ACCESS) && PREADY;
  assign abort = (state == ACCESS) && !PREADY && TO_EN &&
                 ((wait_cnt + 8'd1) == TIMEOUT_C);

  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (done || abort) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // APB outputs double as the captured command. PADDR/PWRITE/PWDATA only
  // change on accept, so they hold their last values while idle.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      wait_cnt    <= 8'd0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_valid_0 <= 1'b0;
      rsp_rdata_0 <= '0;
      rsp_err_0   <= 1'b0;
      rsp_valid_1 <= 1'b0;
      rsp_rdata_1 <= '0;
      rsp_err_1   <= 1'b0;
    end else begin
      rsp_valid_0 <= 1'b0;
      rsp_valid_1 <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            owner      <= winner;
            last_grant <= winner;
            PWRITE     <= winner ? req_write_1 : req_write_0;
            PADDR      <= winner ? req_addr_1  : req_addr_0;
            PWDATA     <= winner ? req_wdata_1 : req_wdata_0;
            wait_cnt   <= 8'd0;
            PSEL       <= 1'b1;
            PENABLE    <= 1'b0;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
        end
        ACCESS: begin
          if (done || abort) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            if (owner) begin
              rsp_valid_1 <= 1'b1;
              rsp_rdata_1 <= (done && !PWRITE) ? PRDATA : '0;
              rsp_err_1   <= done ? PSLVERR : 1'b1;
            end else begin
              rsp_valid_0 <= 1'b1;
              rsp_rdata_0 <= (done && !PWRITE) ? PRDATA : '0;
              rsp_err_0   <= done ? PSLVERR : 1'b1;
            end
          end else if (wait_cnt != 8'hFF) begin
            // Saturate so a disabled timeout never wraps the counter.
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
module tb_apb_req_arbiter;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       preset;
  logic       v0, w0, v1, w1;
  logic [3:0] a0, a1;
  logic [7:0] d0, d1;
  logic [7:0] prdata;
  logic       pready, pslverr;

  logic       req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, rsp_err_0, rsp_err_1;
  logic [7:0] rsp_rdata_0, rsp_rdata_1;
  logic       psel, penable, pwrite;
  logic [3:0] paddr;
  logic [7:0] pwdata;
  logic [1:0] state_dbg;

  // second instance with the timeout disabled
  logic       nt_v0, nt_pready;
  logic       nt_req_ready_0, nt_req_ready_1, nt_rsp_valid_0, nt_rsp_valid_1;
  logic       nt_rsp_err_0, nt_rsp_err_1;
  logic [7:0] nt_rsp_rdata_0, nt_rsp_rdata_1;
  logic       nt_psel, nt_penable, nt_pwrite;
  logic [3:0] nt_paddr;
  logic [7:0] nt_pwdata;
  logic [1:0] nt_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;

  apb_req_arbiter #(.AWIDTH(4), .DWIDTH(8), .TIMEOUT(TO)) u_dut (
    .PCLK(clk), .PRESET(preset),
    .req_valid_0(v0), .req_ready_0(req_ready_0), .req_write_0(w0),
    .req_addr_0(a0), .req_wdata_0(d0),
    .rsp_valid_0(rsp_valid_0), .rsp_rdata_0(rsp_rdata_0), .rsp_err_0(rsp_err_0),
    .req_valid_1(v1), .req_ready_1(req_ready_1), .req_write_1(w1),
    .req_addr_1(a1), .req_wdata_1(d1),
    .rsp_valid_1(rsp_valid_1), .rsp_rdata_1(rsp_rdata_1), .rsp_err_1(rsp_err_1),
    .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
    .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
    .state_dbg(state_dbg)
  );

  apb_req_arbiter #(.AWIDTH(4), .DWIDTH(8), .TIMEOUT(0)) u_dut_nt (
    .PCLK(clk), .PRESET(preset),
    .req_valid_0(nt_v0), .req_ready_0(nt_req_ready_0), .req_write_0(1'b0),
    .req_addr_0(4'h1), .req_wdata_0(8'h00),
    .rsp_valid_0(nt_rsp_valid_0), .rsp_rdata_0(nt_rsp_rdata_0), .rsp_err_0(nt_rsp_err_0),
    .req_valid_1(1'b0), .req_ready_1(nt_req_ready_1), .req_write_1(1'b0),
    .req_addr_1(4'h0), .req_wdata_1(8'h00),
    .rsp_valid_1(nt_rsp_valid_1), .rsp_rdata_1(nt_rsp_rdata_1), .rsp_err_1(nt_rsp_err_1),
    .PSEL(nt_psel), .PENABLE(nt_penable), .PWRITE(nt_pwrite), .PADDR(nt_paddr),
    .PWDATA(nt_pwdata), .PRDATA(prdata), .PREADY(nt_pready), .PSLVERR(pslverr),
    .state_dbg(nt_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // Tracks one in-flight transfer by its age since accept (1 = setup phase,
  // 2+ = access phase) and the number of PREADY-low access cycles seen.
  logic       m_live = 1'b0;
  logic       m_busy, m_owner, m_last;
  int         m_age, m_waits;
  logic       e_psel, e_pen, e_pwrite;
  logic [3:0] e_paddr;
  logic [7:0] e_pwdata;
  logic [1:0] e_rv, e_err;
  logic [7:0] e_rd [2];
  logic [1:0] m_r;

  function automatic logic [1:0] m_ready();
    if (m_busy) return 2'b00;
    if (v0 && v1) return m_last ? 2'b01 : 2'b10;
    return {v1, v0};
  endfunction

  task automatic m_respond(input logic [7:0] rd, input logic err);
    m_busy = 1'b0;
    e_psel = 1'b0;
    e_pen  = 1'b0;
    e_rv[m_owner]  = 1'b1;
    e_rd[m_owner]  = rd;
    e_err[m_owner] = err;
  endtask

  always @(posedge clk) begin
    if (preset) begin
      m_live = 1'b1; m_busy = 1'b0; m_last = 1'b1; m_owner = 1'b0;
      m_age = 0; m_waits = 0;
      e_psel = 0; e_pen = 0; e_pwrite = 0; e_paddr = '0; e_pwdata = '0;
      e_rv = '0; e_err = '0; e_rd[0] = '0; e_rd[1] = '0;
    end else if (m_live) begin
      e_rv = '0;
      if (!m_busy) begin
        m_r = m_ready();
        if (m_r != 2'b00) begin
          m_owner = m_r[1]; m_last = m_r[1]; m_busy = 1'b1;
          m_age = 1; m_waits = 0;
          e_psel = 1'b1; e_pen = 1'b0;
          e_pwrite = m_r[1] ? w1 : w0;
          e_paddr  = m_r[1] ? a1 : a0;
          e_pwdata = m_r[1] ? d1 : d0;
        end
      end else if (m_age == 1) begin
        m_age = 2;
        e_pen = 1'b1;
      end else if (pready) begin
        m_respond(e_pwrite ? 8'h00 : prdata, pslverr);
      end else begin
        m_waits++;
        if (TO != 0 && m_waits == TO) m_respond(8'h00, 1'b1);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_live) begin
      logic [1:0] r;
      r = m_ready();
      chk("req_ready_0", req_ready_0, r[0]);
      chk("req_ready_1", req_ready_1, r[1]);
      chk("PSEL", psel, e_psel);
      chk("PENABLE", penable, e_pen);
      chk("PWRITE", pwrite, e_pwrite);
      chk("PADDR", paddr, e_paddr);
      chk("PWDATA", pwdata, e_pwdata);
      chk("rsp_valid_0", rsp_valid_0, e_rv[0]);
      chk("rsp_valid_1", rsp_valid_1, e_rv[1]);
      chk("rsp_rdata_0", rsp_rdata_0, e_rd[0]);
      chk("rsp_rdata_1", rsp_rdata_1, e_rd[1]);
      chk("rsp_err_0", rsp_err_0, e_err[0]);
      chk("rsp_err_1", rsp_err_1, e_err[1]);
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nr, last_c, ng;
    preset = 1; v0 = 0; w0 = 0; a0 = 0; d0 = 0; v1 = 0; w1 = 0; a1 = 0; d1 = 0;
    prdata = 0; pready = 1; pslverr = 0; nt_v0 = 0; nt_pready = 1;
    tick();
    preset = 0;
    @(negedge clk);
    chk("rst_state_dbg", state_dbg, 2'd0);
    chk("rst_psel", psel, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_rdata0", rsp_rdata_0, 0);
    chk("rst_nt_psel", nt_psel, 0);
    chk("rst_nt_outs", {nt_req_ready_1, nt_rsp_rdata_1, nt_rsp_err_1, nt_pwrite,
                        nt_paddr, nt_pwdata, nt_state}, 0);

    // single write
    tick(); v0 = 1; w0 = 1; a0 = 4'h2; d0 = 8'hA5; pready = 1;
    @(negedge clk); chk("wr_ready0", req_ready_0, 1);
    tick(); v0 = 0;
    @(negedge clk); chk("wr_setup", {psel, penable}, 2'b10);
    tick();
    @(negedge clk);
    chk("wr_access", {psel, penable, pwrite}, 3'b111);
    chk("wr_paddr", paddr, 4'h2);
    chk("wr_pwdata", pwdata, 8'hA5);
    tick();
    @(negedge clk);
    chk("wr_rsp", {rsp_valid_0, rsp_err_0, rsp_rdata_0}, {1'b1, 1'b0, 8'h00});

    // read with three wait states
    tick(); v1 = 1; w1 = 0; a1 = 4'h6; d1 = 8'h11; pready = 0; prdata = 8'h3C;
    @(negedge clk); chk("rd_ready1", req_ready_1, 1);
    tick(); v1 = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 3) pready = 1;
      @(negedge clk); chk("rd_access_phase", {psel, penable}, 2'b11);
    end
    tick();
    @(negedge clk);
    chk("rd_rsp1", {rsp_valid_1, rsp_rdata_1, rsp_err_1}, {1'b1, 8'h3C, 1'b0});
    chk("rd_rsp0_quiet", rsp_valid_0, 0);
    chk("rd_psel_drop", psel, 0);

    // slave error
    tick(); v0 = 1; w0 = 0; a0 = 4'hF; pready = 1; pslverr = 1;
    tick(); v0 = 0;
    tick();
    tick();
    @(negedge clk); chk("err_rsp", {rsp_valid_0, rsp_err_0}, 2'b11);
    tick(); pslverr = 0;
    @(negedge clk); chk("err_pulse_end", {rsp_valid_0, rsp_err_0}, 2'b01);

    // contention from reset: grants 0,1,0,1 every 3 cycles
    tick(); preset = 1; v0 = 1; v1 = 1; w0 = 0; w1 = 0; a0 = 4'h1; a1 = 4'h2;
    prdata = 8'h77; pready = 1;
    tick(); preset = 0;
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd0); exp_q.push_back(2'd1);
    last_c = -1; ng = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("ready_exclusive", req_ready_0 & req_ready_1, 0);
      if (req_ready_0 || req_ready_1) begin
        ng++;
        if (exp_q.size() > 0) chk("grant_order", {1'b0, req_ready_1}, exp_q.pop_front());
        chk("grant_spacing", c - last_c, (last_c < 0) ? c + 1 : 3);
        last_c = c;
      end
    end
    chk("grant_count", ng, 4);
    tick(); v0 = 0; v1 = 0;

    // timeout, then a new command accepted in the following idle cycle
    tick(); v0 = 1; w0 = 0; a0 = 4'h3; pready = 0;
    tick(); v0 = 0; v1 = 1; w1 = 0; a1 = 4'h5;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (psel && penable) n++;
      else if (!psel) break;
    end
    chk("timeout_access_cycles", n, 15);
    chk("timeout_rsp", {rsp_valid_0, rsp_err_0, rsp_rdata_0}, {1'b1, 1'b1, 8'h00});
    chk("timeout_next_accept", req_ready_1, 1);
    tick(); v1 = 0; pready = 1;

    // TIMEOUT=0 instance waits indefinitely
    tick(); nt_v0 = 1; nt_pready = 0; prdata = 8'hC3;
    tick(); nt_v0 = 0;
    n = 0; nr = 0;
    for (int i = 0; i < 101; i++) begin
      @(negedge clk);
      if (nt_psel && nt_penable) n++;
      if (nt_rsp_valid_0 || nt_rsp_valid_1) nr++;
    end
    chk("nt_access_cycles", n, 100);
    chk("nt_no_rsp", nr, 0);
    tick(); nt_pready = 1;
    tick();
    @(negedge clk);
    chk("nt_rsp", {nt_rsp_valid_0, nt_rsp_rdata_0, nt_rsp_err_0}, {1'b1, 8'hC3, 1'b0});

    // reset during ACCESS
    tick(); v0 = 1; w0 = 1; a0 = 4'h9; d0 = 8'h55; pready = 0;
    tick(); v0 = 0;
    tick();
    @(negedge clk); chk("mr_in_access", penable, 1);
    tick(); preset = 1; v0 = 1; v1 = 1; w0 = 0; w1 = 0;
    tick(); preset = 0;
    @(negedge clk);
    chk("mr_apb_zero", {psel, penable, pwrite, paddr, pwdata}, 0);
    chk("mr_no_rsp", {rsp_valid_0, rsp_valid_1}, 2'b00);
    chk("mr_tie_to_0", {req_ready_1, req_ready_0}, 2'b01);
    tick(); v0 = 0; v1 = 0; pready = 1;
    tick(); tick(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
